// File: rtl/seq_detect_mealy_fsm.sv
// ----------------------------------------------------------------------------
// seq_detect_mealy_fsm
//
// Purpose:
//   Mealy sequence detector for a runtime-loadable pattern of up to DEPTH
//   symbols. The state is the number of pattern symbols matched so far.
//   detect_o rises combinationally in the same cycle as the symbol that
//   completes the pattern. A registered copy of that flag is also provided.
//
// Optional feature:
//   Define SEQDET_MATCH_COUNT_EN to build a saturating detection counter on
//   match_count_o. When the macro is not defined, match_count_o is tied to 0
//   and no counter register exists.
//
// Ports:
//   clk_i          - clock; all state changes on the rising edge
//   rst_ni         - synchronous active-low reset
//   data_i         - incoming symbol (SYM_W bits)
//   valid_i        - data_i qualifier; a symbol is consumed only when high
//   load_i         - latch pattern_i / len_i; has priority over valid_i
//   pattern_i      - new pattern, symbol k at bits [k*SYM_W +: SYM_W]
//   len_i          - new pattern length; 0 or > DEPTH is taken as DEPTH
//   detect_o       - combinational match flag
//   detect_q_o     - detect_o delayed by one cycle
//   CurrentState_o - matched-prefix length
//   match_count_o  - number of detections (0 when the counter is not built)
// ----------------------------------------------------------------------------
module seq_detect_mealy_fsm #(
    parameter int                       SYM_W       = 4,
    parameter int                       DEPTH       = 4,
    parameter int                       OVERLAP     = 0,
    parameter logic [DEPTH*SYM_W-1:0]   RST_PATTERN = 16'h9641,
    parameter int                       CNT_W       = 8
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    input  logic [SYM_W-1:0]             data_i,
    input  logic                         valid_i,
    input  logic                         load_i,
    input  logic [DEPTH*SYM_W-1:0]       pattern_i,
    input  logic [$clog2(DEPTH+1)-1:0]   len_i,
    output logic                         detect_o,
    output logic                         detect_q_o,
    output logic [$clog2(DEPTH)-1:0]     CurrentState_o,
    output logic [CNT_W-1:0]             match_count_o
);

    localparam int ST_W  = $clog2(DEPTH);
    localparam int LEN_W = $clog2(DEPTH+1);

    logic [ST_W-1:0]        state_q;
    logic [ST_W-1:0]        state_d;
    logic [DEPTH*SYM_W-1:0] pattern_q;
    logic [DEPTH*SYM_W-1:0] pattern_d;
    logic [LEN_W-1:0]       len_q;
    logic [LEN_W-1:0]       len_d;
    logic                   detect;
    logic                   detect_q;

    logic [SYM_W-1:0]       sym_cur;
    logic                   hit_cur;
    logic                   hit_first;
    logic                   at_last;
    logic                   seed_ok;

    // Lengths of 0 or beyond DEPTH cannot be represented as a real pattern,
    // so they fall back to the full pattern depth.
    function automatic logic [LEN_W-1:0] clamp_len(input logic [LEN_W-1:0] l);
        if (l == '0 || l > LEN_W'(DEPTH)) begin
            return LEN_W'(DEPTH);
        end
        return l;
    endfunction

    // Match helpers. A restart at S=1 is only legal when the pattern has at
    // least two symbols; with len 1 the state must stay at 0.
    assign sym_cur   = pattern_q[int'(state_q)*SYM_W +: SYM_W];
    assign hit_cur   = (data_i == sym_cur);
    assign hit_first = (data_i == pattern_q[SYM_W-1:0]);
    assign at_last   = (LEN_W'(state_q) == (len_q - LEN_W'(1)));
    assign seed_ok   = (len_q > LEN_W'(1));

    // State register: matched-prefix count, active pattern and length, plus
    // the one-cycle delayed detect flag.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q   <= '0;
            pattern_q <= RST_PATTERN;
            len_q     <= LEN_W'(DEPTH);
            detect_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            pattern_q <= pattern_d;
            len_q     <= len_d;
            detect_q  <= detect;
        end
    end

    // Next-state logic. A load wins over a valid symbol and restarts the
    // search with the new pattern. On a mismatch the current symbol may
    // itself be the first symbol of a fresh attempt.
    always_comb begin
        state_d   = state_q;
        pattern_d = pattern_q;
        len_d     = len_q;
        if (load_i) begin
            pattern_d = pattern_i;
            len_d     = clamp_len(len_i);
            state_d   = '0;
        end else if (valid_i) begin
            if (hit_cur) begin
                if (at_last) begin
                    if ((OVERLAP != 0) && hit_first && seed_ok) begin
                        state_d = ST_W'(1);
                    end else begin
                        state_d = '0;
                    end
                end else begin
                    state_d = state_q + ST_W'(1);
                end
            end else begin
                state_d = (hit_first && seed_ok) ? ST_W'(1) : '0;
            end
        end
    end

    // Mealy output: asserted on the symbol completing the pattern, but never
    // while reset is held or a new pattern is being loaded.
    always_comb begin
        detect = 1'b0;
        if (rst_ni && !load_i && valid_i && hit_cur && at_last) begin
            detect = 1'b1;
        end
    end

    assign detect_o       = detect;
    assign detect_q_o     = detect_q;
    assign CurrentState_o = state_q;

`ifdef SEQDET_MATCH_COUNT_EN
    logic [CNT_W-1:0] count_q;

    // Saturating detection counter; a pattern load starts a fresh count.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            count_q <= '0;
        end else if (load_i) begin
            count_q <= '0;
        end else if (detect && (count_q != {CNT_W{1'b1}})) begin
            count_q <= count_q + CNT_W'(1);
        end
    end

    assign match_count_o = count_q;
`else
    assign match_count_o = '0;
`endif

endmodule
